// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM-side signals of sram_arbiter.
// slave = the arbiter; master = the requesters plus the SRAM.
interface sram_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 4
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          busy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
           mem_we, mem_addr, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
           mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-requester front end for a single-port synchronous SRAM.
// Clears the array after reset, then arbitrates and returns tagged read data.
module sram_arbiter #(
  parameter int            AW       = 5,
  parameter int            DW       = 4,
  parameter bit            INIT_EN  = 1'b1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  sram_arbiter_if.slave   bus,
  output logic            dbg_state_o
);
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  localparam state_e RST_STATE = INIT_EN ? ST_INIT : ST_RUN;

  state_e        state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic          last_q, last_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          rd1_v_q, rd1_v_d, rd1_id_q, rd1_id_d;
  logic          rd2_v_q, rd2_id_q;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          gnt0, gnt1, acc0, acc1;

  // Handshake: reqN/weN/addrN/wdataN are held until gntN is seen high at a
  // rising edge; that edge accepts the op. rvalidN is a one-cycle pulse.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_RUN) begin
      if (bus.req0 && (!bus.req1 || last_q)) gnt0 = 1'b1;
      else if (bus.req1)                     gnt1 = 1'b1;
    end
  end

  assign acc0 = bus.req0 & gnt0;
  assign acc1 = bus.req1 & gnt1;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    last_d     = last_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rd1_v_d    = 1'b0;
    rd1_id_d   = rd1_id_q;
    case (state_q)
      ST_INIT: begin
        mem_we_d   = 1'b1;
        mem_addr_d = init_cnt_q;
        mem_din_d  = INIT_VAL;
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) state_d = ST_RUN;
      end
      default: begin
        if (acc0) begin
          mem_we_d   = bus.we0;
          mem_addr_d = bus.addr0;
          mem_din_d  = bus.wdata0;
          rd1_v_d    = ~bus.we0;
          rd1_id_d   = 1'b0;
          last_d     = 1'b0;
        end else if (acc1) begin
          mem_we_d   = bus.we1;
          mem_addr_d = bus.addr1;
          mem_din_d  = bus.wdata1;
          rd1_v_d    = ~bus.we1;
          rd1_id_d   = 1'b1;
          last_d     = 1'b1;
        end
      end
    endcase
  end

  // Stage 1 marks the cycle the address is on the SRAM port, stage 2 the
  // cycle mem_dout is valid; the data is captured at the end of stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      init_cnt_q <= '0;
      last_q     <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rd1_v_q    <= 1'b0;
      rd1_id_q   <= 1'b0;
      rd2_v_q    <= 1'b0;
      rd2_id_q   <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      last_q     <= last_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rd1_v_q    <= rd1_v_d;
      rd1_id_q   <= rd1_id_d;
      rd2_v_q    <= rd1_v_q;
      rd2_id_q   <= rd1_id_q;
      rvalid0_q  <= rd2_v_q & ~rd2_id_q;
      rvalid1_q  <= rd2_v_q & rd2_id_q;
      if (rd2_v_q && !rd2_id_q) rdata0_q <= bus.mem_dout;
      if (rd2_v_q && rd2_id_q)  rdata1_q <= bus.mem_dout;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.busy     = (state_q == ST_INIT);
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign dbg_state_o  = state_q;
endmodule
